// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: shares the CPU bus between the 6502 core, OAM DMA and DMC sample fetches.
// While a DMA engine owns the bus the core is stalled through core_rdy.
module cpu_bus_arbiter (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        cpu_clock,
    input  logic [15:0] core_addr_bus,
    input  logic [7:0]  core_data_out,
    input  logic        core_wr,
    input  logic [7:0]  cpu_data_in,
    input  logic        dmc_req,
    input  logic [15:0] dmc_addr,
    output logic        dmc_ack,
    output logic [7:0]  dmc_data,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data_out,
    output logic        bus_wr,
    output logic        core_rdy,
    output logic        busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HALT   = 3'd1;
    localparam logic [2:0] S_ALIGN  = 3'd2;
    localparam logic [2:0] S_OAM_RD = 3'd3;
    localparam logic [2:0] S_OAM_WR = 3'd4;
    localparam logic [2:0] S_DMC_RD = 3'd5;

    logic [2:0] r_state;
    logic [2:0] w_nextState;
    logic [2:0] w_slot;
    logic [2:0] w_slotAligned;
    logic       r_parity;
    logic       r_oamActive;
    logic       r_dmcAck;
    logic [7:0] r_page;
    logic [7:0] r_cnt;
    logic [7:0] r_oamByte;
    logic [7:0] r_dmcData;
    logic       w_oamTrigger;
    logic       w_dmcReq;

    assign w_oamTrigger = (r_state == S_IDLE) && core_wr && (core_addr_bus == 16'h4014);
    // The request just served stays high until the requester sees ack; never fetch it twice.
    assign w_dmcReq = dmc_req && !r_dmcAck && (r_state != S_DMC_RD);

    always_comb begin
        w_slot = S_IDLE;
        if (w_dmcReq) begin
            w_slot = S_DMC_RD;
        end else if (r_oamActive) begin
            w_slot = S_OAM_RD;
        end
        w_slotAligned = w_slot;
        // Reads must land on get cycles, so burn one dummy cycle when the next one would be a put.
        if ((w_slot != S_IDLE) && r_parity) begin
            w_slotAligned = S_ALIGN;
        end
    end

    always_comb begin
        w_nextState = S_IDLE;
        case (r_state)
            S_IDLE:   w_nextState = (w_oamTrigger || w_dmcReq) ? S_HALT : S_IDLE;
            S_HALT:   w_nextState = w_slotAligned;
            S_ALIGN:  w_nextState = w_slotAligned;
            S_OAM_RD: w_nextState = S_OAM_WR;
            S_OAM_WR: w_nextState = (r_cnt == 8'hFF) ? S_IDLE : w_slotAligned;
            S_DMC_RD: w_nextState = w_slotAligned;
            default:  w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_parity    <= 1'b0;
            r_cnt       <= 8'h00;
            r_page      <= 8'h00;
            r_oamByte   <= 8'h00;
            r_dmcData   <= 8'h00;
            r_oamActive <= 1'b0;
            r_dmcAck    <= 1'b0;
        end else begin
            r_dmcAck <= 1'b0;
            if (cpu_clock) begin
                r_state  <= w_nextState;
                r_parity <= ~r_parity;
                if (w_oamTrigger) begin
                    r_page      <= core_data_out;
                    r_cnt       <= 8'h00;
                    r_oamActive <= 1'b1;
                end
                if (r_state == S_OAM_RD) begin
                    r_oamByte <= cpu_data_in;
                end
                if (r_state == S_OAM_WR) begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == 8'hFF) begin
                        r_oamActive <= 1'b0;
                    end
                end
                if (r_state == S_DMC_RD) begin
                    r_dmcData <= cpu_data_in;
                    r_dmcAck  <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus_addr     = core_addr_bus;
        bus_data_out = core_data_out;
        bus_wr       = 1'b0;
        case (r_state)
            S_IDLE:   bus_wr = core_wr;
            S_OAM_RD: bus_addr = {r_page, r_cnt};
            S_OAM_WR: begin
                bus_addr     = 16'h2004;
                bus_data_out = r_oamByte;
                bus_wr       = 1'b1;
            end
            S_DMC_RD: bus_addr = dmc_addr;
            default:  bus_wr = 1'b0;
        endcase
    end

    assign core_rdy = (r_state == S_IDLE);
    assign busy     = ~core_rdy;
    assign dmc_ack  = r_dmcAck;
    assign dmc_data = r_dmcData;

endmodule
